// File: rtl/placar_pkg.sv
// -----------------------------------------------------------------------------
// placar_pkg
// Shared definitions for the scoreboard sequencing controller:
//   - state_e      : shot-clock FSM state and its 2-bit encoding (debug/LED code)
//   - PTS1..PTS3   : point values carried by the three score buttons
//   - DEF_*        : default values for the controller parameters
//   - pick_points  : priority selection of one score event per cycle
// -----------------------------------------------------------------------------
package placar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [7:0] PTS1 = 8'd1;
    localparam logic [7:0] PTS2 = 8'd2;
    localparam logic [7:0] PTS3 = 8'd3;

    localparam int DEF_MAX_SCORE   = 99;
    localparam int DEF_SHOT_LONG   = 24;
    localparam int DEF_SHOT_SHORT  = 14;
    localparam int DEF_BUZZ_TICKS  = 3;
    localparam int DEF_SYNC_STAGES = 2;

    // Highest-value button wins when several edges land in the same cycle.
    function automatic logic [7:0] pick_points(input logic [2:0] rise);
        logic [7:0] pts;
        if (rise[2]) begin
            pts = PTS3;
        end else if (rise[1]) begin
            pts = PTS2;
        end else if (rise[0]) begin
            pts = PTS1;
        end else begin
            pts = 8'd0;
        end
        return pts;
    endfunction

endpackage

// File: rtl/placar_controle_if.sv
// -----------------------------------------------------------------------------
// placar_controle_if
// Board-side bundle of the scoreboard controller.
//   Inputs to the controller : tick_1hz, btn[2:0], sub, run_sw, reload_sel, reload
//   Outputs of the controller: score[6:0], shot[4:0], buzzer, alert, state[1:0]
// master : the board/stimulus side (drives buttons and switches)
// slave  : the controller itself
// -----------------------------------------------------------------------------
interface placar_controle_if;

    logic       tick_1hz;
    logic [2:0] btn;
    logic       sub;
    logic       run_sw;
    logic       reload_sel;
    logic       reload;

    logic [6:0] score;
    logic [4:0] shot;
    logic       buzzer;
    logic       alert;
    logic [1:0] state;

    modport master (
        output tick_1hz, btn, sub, run_sw, reload_sel, reload,
        input  score, shot, buzzer, alert, state
    );

    modport slave (
        input  tick_1hz, btn, sub, run_sw, reload_sel, reload,
        output score, shot, buzzer, alert, state
    );

endinterface

// File: rtl/placar_controle_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// STAGES-deep synchronizer for one asynchronous input, plus a rising-edge
// detector on the synchronized value.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, clears every flop
//   i_d     : raw asynchronous input
//   o_level : synchronized level (last synchronizer stage, registered)
//   o_rise  : one-cycle pulse when o_level goes 0 -> 1
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift chain plus a delayed copy of the last stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/placar_controle.sv
// -----------------------------------------------------------------------------
// placar_controle
// Sequencing controller for the scoreboard: owns the score register
// (saturating add/subtract of 1/2/3-point events, sticky overflow alert) and
// the shot clock (24/14 reload, run/pause, expiry buzzer) paced by tick_1hz.
//   clk              : system clock
//   reset            : asynchronous active-low reset
//   bus.tick_1hz     : one-cycle 1 Hz strobe, already synchronous to clk
//   bus.btn[2:0]     : raw score buttons, btn[i] is worth i+1 points
//   bus.sub          : 0 = add, 1 = subtract (synchronized level)
//   bus.run_sw       : 1 = shot clock runs, 0 = paused (synchronized level)
//   bus.reload_sel   : reload value select, 0 = SHOT_LONG, 1 = SHOT_SHORT
//   bus.reload       : raw button, rising edge reloads the shot clock
//   bus.score[6:0]   : current score, registered
//   bus.shot[4:0]    : current shot-clock value, registered
//   bus.buzzer       : expiry buzzer, registered
//   bus.alert        : sticky score-overflow flag, registered
//   bus.state[1:0]   : FSM state code, registered
// -----------------------------------------------------------------------------
module placar_controle
    import placar_pkg::*;
#(
    parameter int MAX_SCORE   = DEF_MAX_SCORE,
    parameter int SHOT_LONG   = DEF_SHOT_LONG,
    parameter int SHOT_SHORT  = DEF_SHOT_SHORT,
    parameter int BUZZ_TICKS  = DEF_BUZZ_TICKS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                reset,
    placar_controle_if.slave    bus
);

    localparam logic [7:0] MAX8     = 8'(MAX_SCORE);
    localparam logic [6:0] MAX7     = 7'(MAX_SCORE);
    localparam logic [4:0] L_LONG   = 5'(SHOT_LONG);
    localparam logic [4:0] L_SHORT  = 5'(SHOT_SHORT);
    localparam logic [7:0] L_BUZZ   = 8'(BUZZ_TICKS);

    // Synchronized inputs
    logic [2:0] w_btn_rise;
    logic [2:0] w_btn_lvl;
    logic       w_rl_rise;
    logic       w_rl_lvl;
    logic       w_sub;
    logic       w_sub_rise;
    logic       w_run;
    logic       w_run_rise;
    logic       w_sel;
    logic       w_sel_rise;
    logic       w_unused_ok;

    // Score path
    logic [7:0] w_pts;
    logic [7:0] w_sum;
    logic [6:0] w_score_nxt;
    logic       w_alert_set;

    // Registered state and outputs
    logic [6:0] r_score;
    logic       r_alert;
    state_e     r_state;
    logic [4:0] r_shot;
    logic       r_buzzer;
    logic [7:0] r_buzz_cnt;

    for (genvar g = 0; g < 3; g++) begin : g_btn_sync
        sync_edge #(.STAGES(SYNC_STAGES)) u_btn (
            .clk     (clk),
            .rst_n   (reset),
            .i_d     (bus.btn[g]),
            .o_level (w_btn_lvl[g]),
            .o_rise  (w_btn_rise[g])
        );
    end

    sync_edge #(.STAGES(SYNC_STAGES)) u_reload (
        .clk     (clk),
        .rst_n   (reset),
        .i_d     (bus.reload),
        .o_level (w_rl_lvl),
        .o_rise  (w_rl_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sub (
        .clk     (clk),
        .rst_n   (reset),
        .i_d     (bus.sub),
        .o_level (w_sub),
        .o_rise  (w_sub_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_run (
        .clk     (clk),
        .rst_n   (reset),
        .i_d     (bus.run_sw),
        .o_level (w_run),
        .o_rise  (w_run_rise)
    );

    // reload_sel is a board switch too; it only matters at a reload event,
    // which is itself delayed by the same synchronizer depth.
    sync_edge #(.STAGES(SYNC_STAGES)) u_sel (
        .clk     (clk),
        .rst_n   (reset),
        .i_d     (bus.reload_sel),
        .o_level (w_sel),
        .o_rise  (w_sel_rise)
    );

    // Level/pulse outputs this controller has no use for.
    assign w_unused_ok = ^{w_btn_lvl, w_rl_lvl, w_sub_rise, w_run_rise, w_sel_rise};

    // Next score: 8-bit sum so an overflow past MAX_SCORE is seen, never wrapped.
    always_comb begin
        w_pts       = pick_points(w_btn_rise);
        w_sum       = {1'b0, r_score} + w_pts;
        w_score_nxt = r_score;
        w_alert_set = 1'b0;
        if (w_pts == 8'd0) begin
            w_score_nxt = r_score;
            w_alert_set = 1'b0;
        end else if (!w_sub) begin
            if (w_sum > MAX8) begin
                w_score_nxt = MAX7;
                w_alert_set = 1'b1;
            end else begin
                w_score_nxt = w_sum[6:0];
                w_alert_set = 1'b0;
            end
        end else begin
            if (w_pts > {1'b0, r_score}) begin
                w_score_nxt = 7'd0;
            end else begin
                w_score_nxt = r_score - w_pts[6:0];
            end
            w_alert_set = 1'b0;
        end
    end

    // Score register and sticky alert; events are accepted in every FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_score <= 7'd0;
            r_alert <= 1'b0;
        end else begin
            r_score <= w_score_nxt;
            r_alert <= r_alert | w_alert_set;
        end
    end

    // Shot-clock FSM with registered shot, buzzer and buzz counter.
    // A reload event outranks everything else in the same cycle, ticks included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_shot     <= L_LONG;
            r_buzzer   <= 1'b0;
            r_buzz_cnt <= 8'd0;
        end else if (w_rl_rise) begin
            r_shot     <= w_sel ? L_SHORT : L_LONG;
            r_buzzer   <= 1'b0;
            r_buzz_cnt <= 8'd0;
            r_state    <= w_run ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Pausing wins over a tick arriving in the same cycle.
                    if (!w_run) begin
                        r_state <= ST_PAUSED;
                    end else if (bus.tick_1hz) begin
                        if (r_shot > 5'd1) begin
                            r_shot <= r_shot - 5'd1;
                        end else if (r_shot == 5'd1) begin
                            r_shot     <= 5'd0;
                            r_state    <= ST_EXPIRED;
                            r_buzzer   <= (L_BUZZ != 8'd0);
                            r_buzz_cnt <= L_BUZZ;
                        end else begin
                            r_shot <= 5'd0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (w_run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    r_shot <= 5'd0;
                    if (bus.tick_1hz && (r_buzz_cnt != 8'd0)) begin
                        r_buzz_cnt <= r_buzz_cnt - 8'd1;
                        if (r_buzz_cnt == 8'd1) begin
                            r_buzzer <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.score  = r_score;
    assign bus.shot   = r_shot;
    assign bus.buzzer = r_buzzer;
    assign bus.alert  = r_alert;
    assign bus.state  = r_state;

endmodule

// File: tb/tb_placar_controle.sv
// -----------------------------------------------------------------------------
// tb_placar_controle
// Scoreboard bench: each driven cycle feeds a reference model that works from
// the raw input history (a button press counts when its input was high two
// samples ago and low three samples ago) and pushes the expected outputs; a
// monitor pops and compares after every clock edge.
// -----------------------------------------------------------------------------
module tb_placar_controle;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    placar_controle_if bus();

    placar_controle #(
        .MAX_SCORE(99), .SHOT_LONG(24), .SHOT_SHORT(14),
        .BUZZ_TICKS(3), .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] btn;
        logic       sub;
        logic       run;
        logic       sel;
        logic       rl;
    } in_t;

    typedef struct {
        int score;
        int shot;
        bit buzz;
        bit alert;
        int mode;
    } exp_t;

    exp_t q[$];
    in_t  h[4];

    int vectors     = 0;
    int miscompares = 0;

    int m_score, m_shot, m_mode, m_after;
    bit m_alert, m_buzz;

    logic [2:0] v_btn;
    logic       v_sub, v_run, v_sel, v_rl;

    function automatic void model_reset();
        m_score = 0;
        m_shot  = 24;
        m_mode  = M_IDLE;
        m_after = 0;
        m_alert = 1'b0;
        m_buzz  = 1'b0;
        for (int i = 0; i < 4; i++) h[i] = '0;
    endfunction

    // Expected outputs after the coming clock edge, from the spec's rules.
    task automatic model_edge(input bit tk);
        int pts;
        bit rl_ev;
        pts = 0;
        if (h[2].btn[2] && !h[3].btn[2])      pts = 3;
        else if (h[2].btn[1] && !h[3].btn[1]) pts = 2;
        else if (h[2].btn[0] && !h[3].btn[0]) pts = 1;
        if (pts != 0) begin
            if (!h[2].sub) begin
                if (m_score + pts > 99) begin
                    m_score = 99;
                    m_alert = 1'b1;
                end else begin
                    m_score = m_score + pts;
                end
            end else begin
                m_score = (pts > m_score) ? 0 : m_score - pts;
            end
        end
        rl_ev = h[2].rl && !h[3].rl;
        if (rl_ev) begin
            m_shot = h[2].sel ? 14 : 24;
            m_buzz = 1'b0;
            m_mode = h[2].run ? M_RUN : M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:   if (h[2].run) m_mode = M_RUN;
                M_PAUSED: if (h[2].run) m_mode = M_RUN;
                M_RUN: begin
                    if (!h[2].run) begin
                        m_mode = M_PAUSED;
                    end else if (tk && m_shot > 0) begin
                        m_shot = m_shot - 1;
                        if (m_shot == 0) begin
                            m_mode  = M_EXP;
                            m_buzz  = 1'b1;
                            m_after = 0;
                        end
                    end
                end
                M_EXP: begin
                    if (tk && m_buzz) begin
                        m_after = m_after + 1;
                        if (m_after >= 3) m_buzz = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        q.push_back('{m_score, m_shot, m_buzz, m_alert, m_mode});
    endtask

    // Drive one cycle of inputs at the falling edge and predict the next edge.
    task automatic cyc(input bit tk);
        @(negedge clk);
        bus.btn        = v_btn;
        bus.sub        = v_sub;
        bus.run_sw     = v_run;
        bus.reload_sel = v_sel;
        bus.reload     = v_rl;
        bus.tick_1hz   = tk;
        h[3] = h[2];
        h[2] = h[1];
        h[1] = h[0];
        h[0] = {v_btn, v_sub, v_run, v_sel, v_rl};
        model_edge(tk);
    endtask

    task automatic press(input int idx);
        v_btn[idx] = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        v_btn = 3'b000;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic pulse_reload();
        v_rl = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        v_rl = 1'b0;
        repeat (3) cyc(1'b0);
    endtask

    task automatic tick_gap();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_score"},  32'(bus.score),  32'd0);
        chk({tag, "_shot"},   32'(bus.shot),   32'd24);
        chk({tag, "_buzzer"}, 32'(bus.buzzer), 32'd0);
        chk({tag, "_alert"},  32'(bus.alert),  32'd0);
        chk({tag, "_state"},  32'(bus.state),  32'd0);
    endtask

    task automatic zero_inputs();
        v_btn = 3'b000; v_sub = 1'b0; v_run = 1'b0; v_sel = 1'b0; v_rl = 1'b0;
        bus.btn = 3'b000; bus.sub = 1'b0; bus.run_sw = 1'b0;
        bus.reload_sel = 1'b0; bus.reload = 1'b0; bus.tick_1hz = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(5) == 0) begin
                idx = $urandom_range(2);
                v_btn[idx] = ~v_btn[idx];
            end
            if ($urandom_range(39) == 0) v_sub = ~v_sub;
            if ($urandom_range(29) == 0) v_run = ~v_run;
            if ($urandom_range(24) == 0) v_sel = ~v_sel;
            if ($urandom_range(19) == 0) v_rl  = ~v_rl;
            cyc($urandom_range(2) == 0);
        end
    endtask

    // Monitor: compare the DUT against the next expected entry after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (bus.score !== 7'(e.score) || bus.shot !== 5'(e.shot) ||
                    bus.buzzer !== e.buzz || bus.alert !== e.alert ||
                    bus.state !== 2'(e.mode)) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got score=%0d shot=%0d buzz=%0b alert=%0b state=%0d, expected score=%0d shot=%0d buzz=%0b alert=%0b state=%0d",
                             $time, bus.score, bus.shot, bus.buzzer, bus.alert, bus.state,
                             e.score, e.shot, e.buzz, e.alert, e.mode);
                end
            end
        end
    end

    initial begin
        zero_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;

        // Held button counts once.
        v_btn = 3'b100;
        repeat (5) cyc(1'b0);
        v_btn = 3'b000;
        repeat (3) cyc(1'b0);
        chk("hold_once_score", 32'(bus.score), 32'd3);
        chk("hold_once_alert", 32'(bus.alert), 32'd0);

        // Preload to 97, then saturate.
        repeat (31) press(2);
        press(0);
        chk("preload_97", 32'(bus.score), 32'd97);
        press(2);
        chk("sat_score", 32'(bus.score), 32'd99);
        chk("sat_alert", 32'(bus.alert), 32'd1);
        v_sub = 1'b1;
        press(0);
        chk("sub_after_sat", 32'(bus.score), 32'd98);
        chk("alert_sticky", 32'(bus.alert), 32'd1);

        // Subtract down to 1, then floor at 0.
        repeat (32) press(2);
        press(0);
        chk("down_to_1", 32'(bus.score), 32'd1);
        press(1);
        chk("sub_floor", 32'(bus.score), 32'd0);

        // Two simultaneous edges: only the higher one counts.
        v_sub = 1'b0;
        v_btn = 3'b101;
        cyc(1'b0);
        cyc(1'b0);
        v_btn = 3'b000;
        repeat (3) cyc(1'b0);
        chk("simul_edges", 32'(bus.score), 32'd3);

        // Short reload, count to expiry, buzzer for three ticks.
        v_sel = 1'b1;
        v_run = 1'b1;
        pulse_reload();
        chk("short_reload", 32'(bus.shot), 32'd14);
        chk("short_run", 32'(bus.state), 32'd1);
        repeat (14) tick_gap();
        chk("expired_shot", 32'(bus.shot), 32'd0);
        chk("expired_state", 32'(bus.state), 32'd3);
        chk("buzz_on", 32'(bus.buzzer), 32'd1);
        tick_gap();
        tick_gap();
        chk("buzz_after_2", 32'(bus.buzzer), 32'd1);
        tick_gap();
        chk("buzz_after_3", 32'(bus.buzzer), 32'd0);
        tick_gap();
        chk("expired_hold", 32'(bus.shot), 32'd0);

        // Long reload, count to 10, pause on a tick cycle.
        v_sel = 1'b0;
        pulse_reload();
        repeat (14) tick_gap();
        chk("run_to_10", 32'(bus.shot), 32'd10);
        v_run = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        chk("pause_shot", 32'(bus.shot), 32'd10);
        chk("pause_state", 32'(bus.state), 32'd2);
        v_run = 1'b1;
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        chk("resume_shot", 32'(bus.shot), 32'd9);

        // Reload and tick in the same cycle at shot=5.
        repeat (4) tick_gap();
        chk("run_to_5", 32'(bus.shot), 32'd5);
        v_rl = 1'b1;
        cyc(1'b0);
        v_rl = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        chk("reload_beats_tick", 32'(bus.shot), 32'd24);
        chk("reload_run_state", 32'(bus.state), 32'd1);

        random_cycles(3000);

        // Asynchronous reset in the middle of a run, ensuring alert is set first.
        v_btn = 3'b000; v_sub = 1'b0; v_rl = 1'b0; v_run = 1'b1;
        repeat (34) press(2);
        pulse_reload();
        tick_gap();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        zero_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        random_cycles(1000);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
